// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: shift modes and FSM states.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_SHL = 3'b000,
    MODE_SHR = 3'b001,
    MODE_ROL = 3'b010,
    MODE_ROR = 3'b011,
    MODE_ASR = 3'b100
  } shift_mode_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Codes above ASR are reserved and leave the register untouched.
  function automatic logic mode_is_valid(input logic [2:0] m);
    return m <= 3'b100;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational single-bit shift of d_i in the selected mode.
module shift_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] d_o,
  output logic             out_o
);

  always_comb begin
    d_o   = d_i;
    out_o = 1'b0;
    case (mode_i)
      MODE_SHL: begin
        d_o   = {d_i[WIDTH-2:0], ser_i};
        out_o = d_i[WIDTH-1];
      end
      MODE_SHR: begin
        d_o   = {ser_i, d_i[WIDTH-1:1]};
        out_o = d_i[0];
      end
      MODE_ROL: begin
        d_o   = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
        out_o = d_i[WIDTH-1];
      end
      MODE_ROR: begin
        d_o   = {d_i[0], d_i[WIDTH-1:1]};
        out_o = d_i[0];
      end
      MODE_ASR: begin
        d_o   = {d_i[WIDTH-1], d_i[WIDTH-1:1]};
        out_o = d_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Loadable shift register that executes bursts of single-bit shifts under a
// small IDLE/SHIFT/DONE controller.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic             ser_in,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_q, ser_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;

  logic [WIDTH-1:0] step_data;
  logic             step_out;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode_i (mode_q),
    .d_i    (data_q),
    .ser_i  (ser_in),
    .d_o    (step_data),
    .out_o  (step_out)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ser_d   = ser_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        // Load has priority; a simultaneous start is dropped entirely.
        if (load) begin
          data_d = data_in;
        end else if (start) begin
          mode_d  = mode;
          rem_d   = count;
          state_d = (count == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (mode_is_valid(mode_q)) begin
          data_d = step_data;
          ser_d  = step_out;
        end
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      ser_q   <= 1'b0;
      rem_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  assign data_out = data_q;
  assign ser_out  = ser_q;
  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);

endmodule
